// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph-row arbiter: glyph geometry, requester ids and the
// printable ASCII window served by the font ROM.
package glyph_pkg;

  localparam int unsigned GLYPH_ROWS = 16;
  localparam int unsigned GLYPH_W    = 8;

  typedef logic [GLYPH_W-1:0] glyph_row_t;
  // Row 0 (top of the glyph) sits at index 0.
  typedef glyph_row_t [GLYPH_ROWS-1:0] glyph_t;

  typedef enum logic {
    REQ_WORD = 1'b0,
    REQ_MAZE = 1'b1
  } req_id_t;

  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;

  function automatic logic char_in_range(input logic [7:0] c);
    return (c >= CHAR_MIN) && (c <= CHAR_MAX);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone valid requester always wins, a tie goes to rr_ptr, and the
// pointer flips to the other requester after every accepted grant.
module rr_arb2
  import glyph_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  req_id_t rr_ptr_q, rr_ptr_d;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr_ptr_q == REQ_WORD) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = grant[0] ? REQ_MAZE : REQ_WORD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= REQ_WORD;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/glyph_row_arbiter.sv
// Shares one font ROM between the word panel and the maze labels; two-stage pipeline returns one
// glyph row per accepted request. Define GLYPH_ARB_STATS_EN for saturating per-requester counters.
module glyph_row_arbiter
  import glyph_pkg::*;
#(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [7:0]       req0_char,
  input  logic [3:0]       req0_row,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [7:0]       req1_char,
  input  logic [3:0]       req1_row,
  output logic             req1_ready,
  output logic             rsp0_valid,
  output logic [7:0]       rsp0_data,
  output logic             rsp1_valid,
  output logic [7:0]       rsp1_data,
  output logic [7:0]       sprite_index,
  input  glyph_t           sprite
`ifdef GLYPH_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  if (NREQ != 2) begin : g_bad_nreq
    $error("glyph_row_arbiter supports NREQ == 2 only");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("glyph_row_arbiter needs CNT_W >= 1");
  end

  logic [1:0] req_valid, grant, ready;
  logic       accept;
  req_id_t    acc_owner;
  logic [7:0] acc_char;
  logic [3:0] acc_row;

  assign req_valid  = {req1_valid, req0_valid};
  // Ready is forced low during reset so nothing is accepted into a pipeline being cleared.
  assign ready      = reset ? 2'b00 : (req_valid & grant);
  assign req0_ready = ready[0];
  assign req1_ready = ready[1];
  assign accept     = |ready;
  assign acc_owner  = ready[1] ? REQ_MAZE : REQ_WORD;
  assign acc_char   = ready[1] ? req1_char : req0_char;
  assign acc_row    = ready[1] ? req1_row : req0_row;

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset   (reset),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  logic       s1_valid_q, s1_oor_q;
  req_id_t    s1_owner_q;
  logic [3:0] s1_row_q;
  logic [7:0] sprite_index_q;
  logic [1:0] rsp_valid_q;
  glyph_row_t rsp0_data_q, rsp1_data_q, s2_row;

  assign s2_row = s1_oor_q ? '0 : sprite[s1_row_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q     <= 1'b0;
      s1_oor_q       <= 1'b0;
      s1_owner_q     <= REQ_WORD;
      s1_row_q       <= '0;
      sprite_index_q <= 8'h00;
      rsp_valid_q    <= 2'b00;
      rsp0_data_q    <= '0;
      rsp1_data_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        sprite_index_q <= acc_char;
        s1_row_q       <= acc_row;
        s1_owner_q     <= acc_owner;
        s1_oor_q       <= !char_in_range(acc_char);
      end
      rsp_valid_q[0] <= s1_valid_q && (s1_owner_q == REQ_WORD);
      rsp_valid_q[1] <= s1_valid_q && (s1_owner_q == REQ_MAZE);
      if (s1_valid_q && (s1_owner_q == REQ_WORD)) rsp0_data_q <= s2_row;
      if (s1_valid_q && (s1_owner_q == REQ_MAZE)) rsp1_data_q <= s2_row;
    end
  end

  assign sprite_index = sprite_index_q;
  assign rsp0_valid   = rsp_valid_q[0];
  assign rsp1_valid   = rsp_valid_q[1];
  assign rsp0_data    = rsp0_data_q;
  assign rsp1_data    = rsp1_data_q;

`ifdef GLYPH_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (ready[0] && !(&cnt0_q)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (ready[1] && !(&cnt1_q)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_glyph_row_arbiter.sv
// Directed and random checks of glyph_row_arbiter against a latency-queue reference model.
module tb_glyph_row_arbiter;
  import glyph_pkg::*;

  localparam int unsigned CNT_W = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [7:0] req0_char, req1_char;
  logic [3:0] req0_row, req1_row;
  logic       rsp0_valid, rsp1_valid;
  logic [7:0] rsp0_data, rsp1_data, sprite_index;
  glyph_t     sprite;
`ifdef GLYPH_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

  always #5 clk = ~clk;

  glyph_row_arbiter #(.NREQ(2), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_char    (req0_char),
    .req0_row     (req0_row),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_char    (req1_char),
    .req1_row     (req1_row),
    .req1_ready   (req1_ready),
    .rsp0_valid   (rsp0_valid),
    .rsp0_data    (rsp0_data),
    .rsp1_valid   (rsp1_valid),
    .rsp1_data    (rsp1_data),
    .sprite_index (sprite_index),
    .sprite       (sprite)
`ifdef GLYPH_ARB_STATS_EN
    ,
    .grant_cnt0   (grant_cnt0),
    .grant_cnt1   (grant_cnt1)
`endif
  );

  // Font ROM stand-in: 'a' carries the real rows, every other code a scrambled pattern.
  function automatic glyph_row_t font_row(input logic [7:0] c, input logic [3:0] r);
    glyph_row_t res;
    if (c == 8'h61) begin
      case (r)
        4'd4:              res = 8'h78;
        4'd5:              res = 8'h0C;
        4'd6:              res = 8'h7C;
        4'd7, 4'd8, 4'd9:  res = 8'hCC;
        4'd10:             res = 8'h76;
        default:           res = 8'h00;
      endcase
    end else begin
      res = c ^ {r, ~r} ^ 8'h3C;
    end
    return res;
  endfunction

  always_comb begin
    sprite = '0;
    for (int r = 0; r < GLYPH_ROWS; r++) sprite[r] = font_row(sprite_index, 4'(r));
  end

  typedef struct {
    int         due;
    int         owner;
    logic [7:0] data;
  } pend_t;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  pend_t      q[$];
  bit         m_ptr;
  logic [7:0] m_data [2];
  logic [7:0] m_sidx;
  int         m_cnt [2];
  bit         m_acc [2];
  int         dut_acc [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr = 1'b0;
    m_data[0] = 8'h00;
    m_data[1] = 8'h00;
    m_sidx = 8'h00;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    m_acc[0] = 1'b0;
    m_acc[1] = 1'b0;
  endtask

  // Called just after a negedge with inputs already driven; returns at the next negedge.
  task automatic tick();
    int         win;
    logic [7:0] c;
    logic [3:0] r;
    bit         ev0, ev1;
    #1;
    win = -1;
    if (!reset) begin
      if (req0_valid && !req1_valid) win = 0;
      else if (req1_valid && !req0_valid) win = 1;
      else if (req0_valid && req1_valid) win = m_ptr ? 1 : 0;
    end
    chk("ready0", 32'(req0_ready), 32'(win == 0));
    chk("ready1", 32'(req1_ready), 32'(win == 1));
    if (req0_ready) dut_acc[0]++;
    if (req1_ready) dut_acc[1]++;
    m_acc[0] = (win == 0);
    m_acc[1] = (win == 1);
    if (win >= 0) begin
      c = (win == 1) ? req1_char : req0_char;
      r = (win == 1) ? req1_row : req0_row;
      q.push_back('{cyc + 2, win, ((c >= 8'h20) && (c <= 8'h7E)) ? font_row(c, r) : 8'h00});
      m_sidx = c;
      m_ptr = (win == 0);
      if (m_cnt[win] < (1 << CNT_W) - 1) m_cnt[win]++;
    end
    @(posedge clk);
    #1;
    cyc++;
    ev0 = 1'b0;
    ev1 = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      if (q[0].owner == 0) ev0 = 1'b1; else ev1 = 1'b1;
      m_data[q[0].owner] = q[0].data;
      void'(q.pop_front());
    end
    chk("rsp0_valid", 32'(rsp0_valid), 32'(ev0));
    chk("rsp1_valid", 32'(rsp1_valid), 32'(ev1));
    chk("rsp0_data", 32'(rsp0_data), 32'(m_data[0]));
    chk("rsp1_data", 32'(rsp1_data), 32'(m_data[1]));
    chk("sprite_index", 32'(sprite_index), 32'(m_sidx));
`ifdef GLYPH_ARB_STATS_EN
    chk("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt[0]));
    chk("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt[1]));
`endif
    @(negedge clk);
  endtask

  // Asynchronous assertion between edges; outputs must clear without waiting for a clock.
  task automatic assert_reset();
    reset = 1'b1;
    #1;
    model_reset();
    chk("rst_rsp0_valid", 32'(rsp0_valid), 32'(0));
    chk("rst_rsp1_valid", 32'(rsp1_valid), 32'(0));
    chk("rst_rsp0_data", 32'(rsp0_data), 32'(0));
    chk("rst_rsp1_data", 32'(rsp1_data), 32'(0));
    chk("rst_sprite_index", 32'(sprite_index), 32'(0));
    chk("rst_ready0", 32'(req0_ready), 32'(0));
  endtask

  task automatic new_req(input int n);
    logic       v;
    logic [7:0] c;
    logic [3:0] r;
    v = ($urandom_range(0, 3) != 0);
    c = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(32, 126));
    r = 4'($urandom);
    if (n == 0) begin
      req0_valid = v; req0_char = c; req0_row = r;
    end else begin
      req1_valid = v; req1_char = c; req1_row = r;
    end
  endtask

  initial begin
    reset = 1'b1;
    req0_valid = 1'b1; req0_char = 8'h61; req0_row = 4'd0;
    req1_valid = 1'b0; req1_char = 8'h00; req1_row = 4'd0;
    dut_acc[0] = 0;
    dut_acc[1] = 0;
    model_reset();
    @(negedge clk);
    tick();
    tick();

    // Simultaneous requests straight out of reset: word panel wins first.
    reset = 1'b0;
    req0_valid = 1'b1; req0_char = 8'h61; req0_row = 4'd10;
    req1_valid = 1'b1; req1_char = 8'h61; req1_row = 4'd6;
    tick();
    req0_valid = 1'b0;
    tick();
    req1_valid = 1'b0;
    chk("sim_rsp0_valid", 32'(rsp0_valid), 32'(1));
    chk("sim_rsp0_data", 32'(rsp0_data), 32'(8'b01110110));
    tick();
    chk("sim_rsp1_valid", 32'(rsp1_valid), 32'(1));
    chk("sim_rsp1_data", 32'(rsp1_data), 32'(8'b01111100));
    tick();

    // Single request latency.
    req0_valid = 1'b1; req0_char = 8'h61; req0_row = 4'd4;
    tick();
    req0_valid = 1'b0;
    tick();
    chk("single_rsp0_valid", 32'(rsp0_valid), 32'(1));
    chk("single_rsp0_data", 32'(rsp0_data), 32'(8'b01111000));
    tick();

    // Out-of-range code returns a blank row at normal latency.
    req1_valid = 1'b1; req1_char = 8'h7F; req1_row = 4'd5;
    tick();
    req1_valid = 1'b0;
    tick();
    chk("oor_rsp1_valid", 32'(rsp1_valid), 32'(1));
    chk("oor_rsp1_data", 32'(rsp1_data), 32'(0));
    tick();

    // Reset the cycle after an acceptance: the response must never appear.
    req0_valid = 1'b1; req0_char = 8'h61; req0_row = 4'd7;
    tick();
    req0_valid = 1'b0;
    assert_reset();
    tick();
    chk("flush_rsp0_valid_a", 32'(rsp0_valid), 32'(0));
    reset = 1'b0;
    tick();
    chk("flush_rsp0_valid_b", 32'(rsp0_valid), 32'(0));
    tick();
    chk("flush_rsp0_valid_c", 32'(rsp0_valid), 32'(0));

    // Fairness from a fresh reset: 8 contended cycles split 4/4.
    assert_reset();
    tick();
    reset = 1'b0;
    dut_acc[0] = 0;
    dut_acc[1] = 0;
    req0_valid = 1'b1; req0_char = 8'h41; req0_row = 4'd1;
    req1_valid = 1'b1; req1_char = 8'h42; req1_row = 4'd2;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (m_acc[0]) begin req0_char = 8'($urandom_range(32, 126)); req0_row = 4'($urandom); end
      if (m_acc[1]) begin req1_char = 8'($urandom_range(32, 126)); req1_row = 4'($urandom); end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("fair_cnt0", 32'(dut_acc[0]), 32'(4));
    chk("fair_cnt1", 32'(dut_acc[1]), 32'(4));
`ifdef GLYPH_ARB_STATS_EN
    chk("fair_grant_cnt0", 32'(grant_cnt0), 32'(4));
    chk("fair_grant_cnt1", 32'(grant_cnt1), 32'(4));
`endif
    tick();
    tick();

    // 20 back-to-back word-panel acceptances; counter saturates in the stats build.
    req0_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      req0_char = 8'($urandom);
      req0_row  = 4'($urandom);
      tick();
    end
    req0_valid = 1'b0;
`ifdef GLYPH_ARB_STATS_EN
    chk("sat_grant_cnt0", 32'(grant_cnt0), 32'(4'hF));
`endif
    tick();
    tick();

    // Random traffic; each requester holds its request until accepted.
    for (int i = 0; i < 400; i++) begin
      if (!req0_valid || m_acc[0]) new_req(0);
      if (!req1_valid || m_acc[1]) new_req(1);
      if (i == 200) begin
        assert_reset();
        tick();
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      tick();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/glyph_row_arbiter.md
GLYPH_ROW_ARBITER -- requirements
Module: glyph_row_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters; only the value 2 is supported.
REQ-002 Parameter CNT_W, default 16, width of grant statistics counters.
REQ-003 Clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) glyph-row request pending; N=0 is the word panel, N=1 is the maze tile labels.
REQ-006 reqN_char  input  8  (N=0,1) character code, ASCII.
REQ-007 reqN_row  input  4  (N=0,1) glyph row, 0 = top.
REQ-008 reqN_ready  output  1  (N=0,1) request accepted this cycle (combinational grant).
REQ-009 rspN_valid  output  1  (N=0,1) one-cycle pulse; rspN_data is valid.
REQ-010 rspN_data  output  8  (N=0,1) glyph row bits; bit 7 is the leftmost pixel.
REQ-011 sprite_index  output  8  registered character code driven to the font ROM.
REQ-012 sprite  input  16x8  combinational font ROM glyph rows, row 0 first.
REQ-013 grant_cntN  output  CNT_W  (N=0,1) accepted-request count; present only with GLYPH_ARB_STATS_EN.

Function
REQ-014 Request accepted on a rising edge where reqN_valid && reqN_ready; at most one acceptance per cycle.
REQ-015 reqN_ready SHALL be asserted only while reqN_valid is high and requester N holds the grant; never asserted for both requesters in one cycle.
REQ-016 Only one requester valid: it is granted that cycle.
REQ-017 Both valid: the requester named by the round-robin pointer rr_ptr is granted; rr_ptr moves to the other requester after every acceptance, and is unchanged on cycles with no acceptance.
REQ-018 Requester obligation: char and row held stable, valid not deasserted, until accepted; the arbiter does not check this.
REQ-019 Pipeline: stage S1 registers sprite_index, row and owner id on acceptance; stage S2 registers sprite[row] into the owner's rspN_data on the following edge.
REQ-020 Latency: acceptance at edge E -> rspN_valid high for exactly the cycle after edge E+1; throughput one row per cycle, back-to-back acceptances allowed.
REQ-021 Out-of-range characters (below 0x20 or above 0x7E) SHALL return rspN_data = 8'h00 with unchanged timing.
REQ-022 No response backpressure; rspN_valid is a pulse the requester must capture.
REQ-023 Non-owner rspN_data holds its last value; rspN_valid is low for the non-owner.
REQ-024 sprite_index holds its value on cycles with no acceptance.

Reset
REQ-025 Reset asserted: rr_ptr=0, S1/S2 valids=0, rspN_valid=0, rspN_data=8'h00, sprite_index=8'h00, grant_cntN=0.
REQ-026 Reset asserted mid-operation discards in-flight requests; no response issued for them after release.
REQ-027 reqN_ready SHALL be low while Reset is high.

Configuration
REQ-028 Macro GLYPH_ARB_STATS_EN defined: grant_cntN ports and counters exist, incrementing on each acceptance and saturating at all-ones.
REQ-029 Macro undefined: no counter ports or logic; all other behaviour identical.

Structure
REQ-030 Package glyph_pkg SHALL hold GLYPH_ROWS=16, GLYPH_W=8, typedefs glyph_row_t (8-bit) and glyph_t (16 x glyph_row_t), the requester id enum {REQ_WORD, REQ_MAZE}, and constants CHAR_MIN=8'h20, CHAR_MAX=8'h7E.
REQ-031 Round-robin grant SHALL be sub-module rr_arb2 (inputs two valids, an advance strobe; outputs one-hot grant; owns rr_ptr).

Verification
REQ-032 Single request: req0 char 8'h61, row 4 at edge E -> rsp0_valid in cycle after E+1, rsp0_data=8'b01111000.
REQ-033 Simultaneous: both valid from reset, req0 8'h61 row 10, req1 8'h61 row 6 -> req0 granted first (rsp0_data=8'b01110110), req1 next cycle (rsp1_data=8'b01111100).
REQ-034 Fairness: both held valid 8 cycles -> grants alternate 0,1,0,1...; exactly 4 each; counters read 4 with GLYPH_ARB_STATS_EN.
REQ-035 Out-of-range: req1 char 8'h7F row 5 -> rsp1_valid with rsp1_data=8'h00 at normal latency.
REQ-036 Reset mid-flight: accept req0, assert Reset the next cycle -> no rsp0_valid; all outputs at reset values.
REQ-037 Saturation (STATS build, CNT_W=4): 20 consecutive req0 acceptances -> grant_cnt0=4'hF.
